// File: rtl/mem_req_arbiter_if.sv
// Bus bundle between the I$/D$ miss paths, the arbiter and the memory port.
// The arbiter side uses the slave modport; the cache/memory side uses master.
interface mem_req_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128
) ();
    logic                  icache_req_valid;
    logic [ADDR_WIDTH-1:0] icache_req_addr;
    logic                  dcache_req_valid;
    logic [ADDR_WIDTH-1:0] dcache_req_addr;
    logic                  dcache_req_is_store;
    logic [LINE_WIDTH-1:0] dcache_req_data;
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic                  mem_req_is_store;
    logic [LINE_WIDTH-1:0] mem_req_data;
    logic                  mem_rsp_valid;
    logic [LINE_WIDTH-1:0] mem_rsp_data;
    logic                  rsp_valid_miss;
    logic                  rsp_cache_id;
    logic [LINE_WIDTH-1:0] rsp_data_miss;
    logic                  protocol_error;

    modport slave (
        input  icache_req_valid, icache_req_addr,
        input  dcache_req_valid, dcache_req_addr, dcache_req_is_store, dcache_req_data,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output mem_req_valid, mem_req_addr, mem_req_is_store, mem_req_data,
        output rsp_valid_miss, rsp_cache_id, rsp_data_miss, protocol_error
    );

    modport master (
        output icache_req_valid, icache_req_addr,
        output dcache_req_valid, dcache_req_addr, dcache_req_is_store, dcache_req_data,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  mem_req_valid, mem_req_addr, mem_req_is_store, mem_req_data,
        input  rsp_valid_miss, rsp_cache_id, rsp_data_miss, protocol_error
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// Arbitrates one outstanding I$/D$ miss each onto the single memory port,
// D$ first with a bounded-starvation guard for I$.
module mem_req_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int LINE_WIDTH  = 128,
    parameter int REQ_LATENCY = 4,
    parameter int MAX_D_WINS  = 3
) (
    input  logic             clock,
    input  logic             reset,
    mem_req_arbiter_if.slave bus
);
    localparam int CW = $clog2(REQ_LATENCY + 1);
    localparam int DW = $clog2(MAX_D_WINS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(REQ_LATENCY - 1);
    localparam logic [DW-1:0] WINS_MAX = DW'(MAX_D_WINS);

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_ISSUE, S_WAIT_RSP} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_pend_i;
    logic                  r_pend_d;
    logic [ADDR_WIDTH-1:0] r_i_addr;
    logic [ADDR_WIDTH-1:0] r_d_addr;
    logic                  r_d_store;
    logic [LINE_WIDTH-1:0] r_d_data;
    logic                  r_sel;
    logic [CW-1:0]         r_cnt;
    logic [DW-1:0]         r_d_wins;
    logic                  r_rsp_valid;
    logic                  r_rsp_id;
    logic [LINE_WIDTH-1:0] r_rsp_data;
    logic                  r_perr;
    logic                  w_grant_i;
    logic                  w_grant_d;
    logic                  w_done;
    logic                  w_clr_i;
    logic                  w_clr_d;
    logic                  w_issue;

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                // D$ wins unless I$ has already lost MAX_D_WINS times in a row
                if (r_pend_d && !(r_pend_i && r_d_wins == WINS_MAX)) begin
                    w_grant_d    = 1'b1;
                    w_state_next = S_DELAY;
                end else if (r_pend_i) begin
                    w_grant_i    = 1'b1;
                    w_state_next = S_DELAY;
                end
            end
            S_DELAY:    if (r_cnt == CNT_LAST) w_state_next = S_ISSUE;
            S_ISSUE:    if (bus.mem_req_ready) w_state_next = S_WAIT_RSP;
            S_WAIT_RSP: begin
                if (bus.mem_rsp_valid) begin
                    w_done       = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default:    w_state_next = S_IDLE;
        endcase
    end

    assign w_clr_i = w_done && !r_sel;
    assign w_clr_d = w_done && r_sel;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pend_i    <= 1'b0;
            r_pend_d    <= 1'b0;
            r_i_addr    <= '0;
            r_d_addr    <= '0;
            r_d_store   <= 1'b0;
            r_d_data    <= '0;
            r_sel       <= 1'b0;
            r_cnt       <= '0;
            r_d_wins    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_data  <= '0;
            r_perr      <= 1'b0;
        end else begin
            if (w_grant_i || w_grant_d) begin
                r_sel <= w_grant_d;
                r_cnt <= '0;
            end else if (r_state == S_DELAY) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (!r_pend_i || w_grant_i)
                r_d_wins <= '0;
            else if (w_grant_d && r_d_wins != WINS_MAX)
                r_d_wins <= r_d_wins + 1'b1;

            r_rsp_valid <= w_done;
            if (w_done) begin
                r_rsp_id   <= r_sel;
                r_rsp_data <= (r_sel && r_d_store) ? '0 : bus.mem_rsp_data;
            end

            // A request coinciding with its own cache's response is captured
            if (bus.icache_req_valid) begin
                if (r_pend_i && !w_clr_i) begin
                    r_perr <= 1'b1;
                end else begin
                    r_pend_i <= 1'b1;
                    r_i_addr <= bus.icache_req_addr;
                end
            end else if (w_clr_i) begin
                r_pend_i <= 1'b0;
            end

            if (bus.dcache_req_valid) begin
                if (r_pend_d && !w_clr_d) begin
                    r_perr <= 1'b1;
                end else begin
                    r_pend_d  <= 1'b1;
                    r_d_addr  <= bus.dcache_req_addr;
                    r_d_store <= bus.dcache_req_is_store;
                    r_d_data  <= bus.dcache_req_data;
                end
            end else if (w_clr_d) begin
                r_pend_d <= 1'b0;
            end
        end
    end

    assign w_issue              = (r_state == S_ISSUE);
    assign bus.mem_req_valid    = w_issue;
    assign bus.mem_req_addr     = w_issue ? (r_sel ? r_d_addr : r_i_addr) : '0;
    assign bus.mem_req_is_store = w_issue && r_sel && r_d_store;
    assign bus.mem_req_data     = (w_issue && r_sel) ? r_d_data : '0;
    assign bus.rsp_valid_miss   = r_rsp_valid;
    assign bus.rsp_cache_id     = r_rsp_id;
    assign bus.rsp_data_miss    = r_rsp_data;
    assign bus.protocol_error   = r_perr;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: directed vector table, corner-case sequences and
// random traffic checked against a transaction-level model.
module tb_mem_req_arbiter;
    localparam int AW   = 32;
    localparam int LW   = 128;
    localparam int LAT  = 4;
    localparam int MAXW = 3;
    localparam int OW   = 1 + AW + 1 + LW + 1 + 1 + LW + 1;
    typedef logic [OW-1:0] ov_t;
    localparam logic [LW-1:0] DB = 128'hDEAD_0123_4567_89AB_CDEF_0123_4567_BEEF;
    localparam logic [LW-1:0] A5 = {16{8'hA5}};

    // ctl = {rst, ireq, dreq, dstore, ready, rspv}; ef = {mv, mst, rv, rid, err}
    typedef struct {
        logic [5:0]    ctl;
        logic [AW-1:0] addr;
        logic [LW-1:0] din;
        logic [4:0]    ef;
        logic [AW-1:0] ea;
        logic [LW-1:0] ed;
        logic [LW-1:0] er;
    } vec_t;

    logic clock = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    int   acc_cnt = 0;
    vec_t tbl[$];

    always #5 clock = ~clock;

    mem_req_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

    mem_req_arbiter #(
        .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .REQ_LATENCY(LAT), .MAX_D_WINS(MAXW)
    ) u_dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always @(posedge clock) if (!reset && bus.mem_req_valid && bus.mem_req_ready) acc_cnt++;

    // Transaction model: a granted miss waits LAT cycles, is offered until
    // accepted, then completes on the first memory response.
    bit            m_pend[2];
    logic [AW-1:0] m_addr[2];
    bit            m_store[2];
    logic [LW-1:0] m_data[2];
    bit            m_busy, m_acc, m_sel, m_rv, m_rid, m_err;
    int            m_left, m_wins;
    logic [LW-1:0] m_rdata;

    always @(posedge clock) begin : p_model
        bit fin, gi, gd, clr;
        bit req[2];
        if (reset) begin
            m_pend = '{0, 0};
            m_busy = 0; m_acc = 0; m_sel = 0; m_left = 0; m_wins = 0;
            m_rv = 0; m_rid = 0; m_rdata = '0; m_err = 0;
        end else begin
            fin  = m_busy && m_acc && bus.mem_rsp_valid;
            m_rv = fin;
            if (fin) begin
                m_rid   = m_sel;
                m_rdata = m_store[m_sel] ? '0 : bus.mem_rsp_data;
            end
            gd = 0; gi = 0;
            if (!m_busy) begin
                if (m_pend[1] && !(m_pend[0] && m_wins == MAXW)) gd = 1;
                else if (m_pend[0]) gi = 1;
            end
            if (!m_pend[0] || gi) m_wins = 0;
            else if (gd && m_wins < MAXW) m_wins++;
            if (m_busy) begin
                if (m_left > 0) m_left--;
                else if (!m_acc && bus.mem_req_ready) m_acc = 1;
                else if (fin) m_busy = 0;
            end else if (gi || gd) begin
                m_busy = 1; m_sel = gd; m_left = LAT; m_acc = 0;
            end
            req[0] = bus.icache_req_valid;
            req[1] = bus.dcache_req_valid;
            for (int x = 0; x < 2; x++) begin
                clr = fin && (int'(m_sel) == x);
                if (req[x] && m_pend[x] && !clr) begin
                    m_err = 1;
                end else if (req[x]) begin
                    m_pend[x]  = 1;
                    m_addr[x]  = (x == 1) ? bus.dcache_req_addr : bus.icache_req_addr;
                    m_store[x] = (x == 1) ? bus.dcache_req_is_store : 1'b0;
                    m_data[x]  = (x == 1) ? bus.dcache_req_data : '0;
                end else if (clr) begin
                    m_pend[x] = 0;
                end
            end
        end
    end

    function automatic ov_t mdl_out();
        bit mv;
        mv = m_busy && m_left == 0 && !m_acc;
        return {mv, mv ? m_addr[m_sel] : {AW{1'b0}}, mv && m_store[m_sel],
                mv ? m_data[m_sel] : {LW{1'b0}}, m_rv, m_rid, m_rdata, m_err};
    endfunction

    function automatic ov_t dut_out();
        return {bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_is_store, bus.mem_req_data,
                bus.rsp_valid_miss, bus.rsp_cache_id, bus.rsp_data_miss, bus.protocol_error};
    endfunction

    function automatic vec_t mk(input logic [5:0] c, input logic [AW-1:0] a, input logic [LW-1:0] d,
                                input logic [4:0] ef, input logic [AW-1:0] ea,
                                input logic [LW-1:0] ed, input logic [LW-1:0] er);
        return '{c, a, d, ef, ea, ed, er};
    endfunction

    task automatic chk(input string nm, input ov_t act, input ov_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic clr_in();
        bus.icache_req_valid = 0; bus.icache_req_addr = '0;
        bus.dcache_req_valid = 0; bus.dcache_req_addr = '0;
        bus.dcache_req_is_store = 0; bus.dcache_req_data = '0;
        bus.mem_req_ready = 0; bus.mem_rsp_valid = 0; bus.mem_rsp_data = '0;
    endtask

    task automatic do_reset();
        clr_in();
        reset = 1; tick(); tick();
        reset = 0;
    endtask

    task automatic wait_req(output bit ok);
        int n = 0;
        while (!bus.mem_req_valid && n < 40) begin tick(); n++; end
        ok = bus.mem_req_valid;
        if (!ok) chk("req_timeout", ov_t'(bus.mem_req_valid), ov_t'(1));
    endtask

    // Accept one request, respond two cycles later, optionally re-requesting D$
    // in the response cycle; returns at the cycle the response pulse is visible.
    task automatic serve(input logic [LW-1:0] rdata, input bit dre, input logic [AW-1:0] dre_addr,
                         output logic [AW-1:0] got_addr, output logic got_id);
        bit ok;
        got_addr = '0; got_id = 0;
        wait_req(ok);
        if (ok) begin
            got_addr = bus.mem_req_addr;
            bus.mem_req_ready = 1; tick(); bus.mem_req_ready = 0;
            chk("req_drop", ov_t'(bus.mem_req_valid), ov_t'(0));
            tick(); tick();
            bus.mem_rsp_valid = 1; bus.mem_rsp_data = rdata;
            if (dre) begin bus.dcache_req_valid = 1; bus.dcache_req_addr = dre_addr; end
            tick(); clr_in();
            chk("rsp_pulse", ov_t'(bus.rsp_valid_miss), ov_t'(1));
            got_id = bus.rsp_cache_id;
        end
    endtask

    initial begin
        logic [AW-1:0] a;
        logic          id;
        logic [4:0]    ids;
        int            acc0;
        bit            ok;

        clr_in(); reset = 1; tick();

        // I$ load of 0x1000, then a D$ store of 0x200 with ready held low
        tbl.push_back(mk(6'b100000, '0, '0, 5'b00000, '0, '0, '0));
        tbl.push_back(mk(6'b010010, 32'h1000, '0, 5'b00000, '0, '0, '0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(6'b000010, '0, '0, 5'b00000, '0, '0, '0));
        tbl.push_back(mk(6'b000010, '0, '0, 5'b10000, 32'h1000, '0, '0));
        tbl.push_back(mk(6'b000010, '0, '0, 5'b00000, '0, '0, '0));
        for (int i = 0; i < 2; i++) tbl.push_back(mk(6'b000000, '0, '0, 5'b00000, '0, '0, '0));
        tbl.push_back(mk(6'b000001, '0, DB, 5'b00100, '0, '0, DB));
        tbl.push_back(mk(6'b000000, '0, '0, 5'b00000, '0, '0, DB));
        tbl.push_back(mk(6'b001100, 32'h200, A5, 5'b00000, '0, '0, DB));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(6'b000000, '0, '0, 5'b00000, '0, '0, DB));
        for (int i = 0; i < 6; i++) tbl.push_back(mk(6'b000000, '0, '0, 5'b11000, 32'h200, A5, DB));
        tbl.push_back(mk(6'b000010, '0, '0, 5'b00000, '0, '0, DB));
        tbl.push_back(mk(6'b000001, '0, A5, 5'b00110, '0, '0, '0));
        tbl.push_back(mk(6'b000000, '0, '0, 5'b00010, '0, '0, '0));

        for (int k = 0; k < tbl.size(); k++) begin
            reset                   = tbl[k].ctl[5];
            bus.icache_req_valid    = tbl[k].ctl[4];
            bus.dcache_req_valid    = tbl[k].ctl[3];
            bus.dcache_req_is_store = tbl[k].ctl[2];
            bus.mem_req_ready       = tbl[k].ctl[1];
            bus.mem_rsp_valid       = tbl[k].ctl[0];
            bus.icache_req_addr     = tbl[k].addr;
            bus.dcache_req_addr     = tbl[k].addr;
            bus.dcache_req_data     = tbl[k].din;
            bus.mem_rsp_data        = tbl[k].din;
            tick();
            chk($sformatf("vec%0d", k), dut_out(),
                {tbl[k].ef[4], tbl[k].ea, tbl[k].ef[3], tbl[k].ed,
                 tbl[k].ef[2], tbl[k].ef[1], tbl[k].er, tbl[k].ef[0]});
        end

        // Simultaneous requests: D$ first, then I$, one accept each
        do_reset(); acc0 = acc_cnt;
        bus.icache_req_valid = 1; bus.icache_req_addr = 32'h40;
        bus.dcache_req_valid = 1; bus.dcache_req_addr = 32'h80;
        tick(); clr_in();
        serve(DB, 0, '0, a, id);
        chk("sim_first", ov_t'({id, a}), ov_t'({1'b1, 32'h80}));
        serve(A5, 0, '0, a, id);
        chk("sim_second", ov_t'({id, a}), ov_t'({1'b0, 32'h40}));
        chk("sim_rdata", ov_t'(bus.rsp_data_miss), ov_t'(A5));
        chk("sim_accepts", ov_t'(acc_cnt - acc0), ov_t'(2));

        // Starvation guard: D$ re-requests in every D$ response cycle
        do_reset();
        bus.icache_req_valid = 1; bus.icache_req_addr = 32'h300;
        bus.dcache_req_valid = 1; bus.dcache_req_addr = 32'hD00;
        tick(); clr_in();
        ids = '0;
        for (int k = 0; k < 5; k++) begin
            serve(DB, k < 3, 32'hD00 + 32'(k), a, id);
            ids[4-k] = id;
            if (k == 3) chk("starve_iaddr", ov_t'(a), ov_t'(32'h300));
        end
        chk("starve_order", ov_t'(ids), ov_t'(5'b11101));
        chk("starve_noerr", ov_t'(bus.protocol_error), ov_t'(0));

        // Duplicate D$ request: ignored, sticky error until reset
        do_reset();
        bus.dcache_req_valid = 1; bus.dcache_req_addr = 32'h500;
        tick(); clr_in(); tick();
        bus.dcache_req_valid = 1; bus.dcache_req_addr = 32'h600;
        tick(); clr_in();
        chk("perr_set", ov_t'(bus.protocol_error), ov_t'(1));
        serve(DB, 0, '0, a, id);
        chk("perr_orig", ov_t'({id, a}), ov_t'({1'b1, 32'h500}));
        tick(); tick();
        chk("perr_hold", ov_t'(bus.protocol_error), ov_t'(1));
        reset = 1; tick(); reset = 0;
        chk("perr_clr", ov_t'(bus.protocol_error), ov_t'(0));

        // Reset while waiting for the response: late response is dropped
        do_reset();
        bus.icache_req_valid = 1; bus.icache_req_addr = 32'h700;
        tick(); clr_in();
        wait_req(ok);
        bus.mem_req_ready = 1; tick(); bus.mem_req_ready = 0; tick();
        reset = 1; tick(); reset = 0;
        chk("rst_outs", dut_out(), '0);
        bus.mem_rsp_valid = 1; bus.mem_rsp_data = DB; tick(); clr_in();
        chk("rst_norsp", dut_out(), '0);
        tick();
        chk("rst_idle", dut_out(), '0);
        bus.icache_req_valid = 1; bus.icache_req_addr = 32'h800;
        tick(); clr_in();
        serve(DB, 0, '0, a, id);
        chk("rst_after", ov_t'({id, a}), ov_t'({1'b0, 32'h800}));
        chk("rst_rdata", ov_t'(bus.rsp_data_miss), ov_t'(DB));

        // Random traffic against the model, including stray responses and resets
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            chk("rand", dut_out(), mdl_out());
            reset                   = ($urandom_range(0, 199) == 0);
            bus.icache_req_valid    = ($urandom_range(0, 5) == 0);
            bus.icache_req_addr     = $urandom;
            bus.dcache_req_valid    = ($urandom_range(0, 5) == 0);
            bus.dcache_req_addr     = $urandom;
            bus.dcache_req_is_store = $urandom_range(0, 1) == 1;
            bus.dcache_req_data     = {$urandom, $urandom, $urandom, $urandom};
            bus.mem_req_ready       = $urandom_range(0, 1) == 1;
            bus.mem_rsp_valid       = ($urandom_range(0, 2) == 0);
            bus.mem_rsp_data        = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Shares the single main-memory port between the instruction cache and the data cache miss paths. Sits between core_top's icache/dcache miss interfaces and the main memory model (or a future memory controller).
- Captures one outstanding miss per cache. Grants D$ first, with a bounded-starvation guard for I$.
- Emulates the request latency, issues the request with a valid/ready handshake, waits for the memory response and routes it back with a cache id.

Parameters:
ADDR_WIDTH, 32, width of the line address in a miss request
LINE_WIDTH, 128, cache line / memory line width in bits
REQ_LATENCY, 4, cycles spent in DELAY before the memory request is issued (≥1)
MAX_D_WINS, 3, max consecutive D$ grants while I$ is pending before I$ is forced (≥1)

Ports:
clock  in  1  core clock
reset  in  1  synchronous, active-high reset
icache_req_valid  in  1  one-cycle pulse: I$ miss request
icache_req_addr  in  ADDR_WIDTH  I$ line address
dcache_req_valid  in  1  one-cycle pulse: D$ miss request
dcache_req_addr  in  ADDR_WIDTH  D$ line address
dcache_req_is_store  in  1  1 = write-back of dcache_req_data
dcache_req_data  in  LINE_WIDTH  write-back line
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request this cycle
mem_req_addr  out  ADDR_WIDTH  granted address
mem_req_is_store  out  1  granted op type (always 0 for I$)
mem_req_data  out  LINE_WIDTH  granted store data
mem_rsp_valid  in  1  one-cycle memory response (load data or store ack)
mem_rsp_data  in  LINE_WIDTH  load data
rsp_valid_miss  out  1  one-cycle response to the caches
rsp_cache_id  out  1  0 = I$, 1 = D$
rsp_data_miss  out  LINE_WIDTH  line data (0 for store acks)
protocol_error  out  1  sticky: new request while the same cache already has one pending

Behaviour:
- Clock and reset: one clock (clock). Reset is synchronous and active-high (reset), sampled on the posedge.
- Reset state: FSM in IDLE; pending flags, counters and win counter cleared. All outputs 0 during and after reset, including mem_req_*, rsp_* and protocol_error.
- Capture: *_req_valid sets pending_X and latches addr/is_store/data into a per-cache holding register.
  - Request arriving while pending_X is already set: ignored (holding register unchanged); protocol_error set to 1 and held until reset.
  - A new request in the same cycle that the response for cache X is returned is legal and is captured (set wins over clear).
- FSM states: IDLE → DELAY → ISSUE → WAIT_RSP → IDLE.
- IDLE: grant evaluated against the registered pending flags only, so a request captured at edge N can be granted at edge N+1, never N.
  - Only one cache pending: grant it.
  - Both pending: grant D$ unless d_wins == MAX_D_WINS, in which case grant I$.
  - Grant latches sel (0/1) and loads cnt = 0; go to DELAY.
- d_wins: incremented on a D$ grant while pending_I is set; cleared on any I$ grant or whenever pending_I is 0. Saturates at MAX_D_WINS.
- DELAY: cnt increments each cycle; when cnt == REQ_LATENCY-1 go to ISSUE. Exactly REQ_LATENCY cycles are spent in DELAY.
- ISSUE: mem_req_valid = 1; mem_req_addr/is_store/data come from the selected holding register and stay stable until accepted. On mem_req_ready go to WAIT_RSP (valid drops the next cycle).
- WAIT_RSP: on mem_rsp_valid, register the response for the next cycle:
  - rsp_valid_miss = 1, rsp_cache_id = sel.
  - rsp_data_miss = mem_rsp_data for loads, 0 for stores.
  - Clear pending_sel; go to IDLE.
  - mem_rsp_valid outside WAIT_RSP is ignored.
- Response outputs: rsp_valid_miss is a single-cycle pulse. rsp_data_miss and rsp_cache_id hold their last value otherwise.
- Turnaround: the next grant can occur in the cycle the response pulse is visible.
- Non-preemptive: a D$ request arriving during an I$ transaction waits for it to complete.
- Reset mid-transaction: aborts immediately to the reset state; no response is emitted.
- Width rules: cnt is $clog2(REQ_LATENCY+1) bits; d_wins is $clog2(MAX_D_WINS+1) bits.

Test Plan:
- Single I$ load: icache_req addr 0x1000; memory ready=1, responds 3 cycles after accept with 0xDEAD…BEEF → mem_req_valid asserts 1+REQ_LATENCY cycles after the pulse; rsp_valid_miss=1, id=0, data=0xDEAD…BEEF one cycle after mem_rsp_valid.
- Simultaneous I$ 0x40 and D$ 0x80 pulses → D$ served first (id=1), then I$ (id=0); exactly one mem_req accepted per transaction.
- D$ store 0x200, data 0xA5…A5 with mem_req_ready held low 5 cycles → addr/data/is_store stable throughout; response id=1, data=0.
- Starvation, MAX_D_WINS=3: I$ pending, D$ re-requests immediately after every response → grant order D,D,D,I.
- Second dcache_req_valid while D$ pending → ignored, protocol_error=1 until reset; original request completes with its original address.
- Reset asserted in WAIT_RSP, then mem_rsp_valid → no rsp_valid_miss; all outputs 0; a new I$ request is then served normally.
